// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one outstanding read to instruction
// memory and buffers {pc, instr} pairs for decode. A redirect flushes the queue.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] redir_addr;
  logic [63:0] stor [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_next;
  logic        push, pop;

  assign redir_addr = redirect_pc & ~32'd3;
  assign out_valid  = (count != '0);
  assign out_pc     = out_valid ? stor[rd_ptr][63:32] : 32'd0;
  assign out_instr  = out_valid ? stor[rd_ptr][31:0]  : 32'd0;

  always_comb begin
    push = (state == REQ) && mem_ack && !redirect_valid;
    pop  = out_valid && out_ready && !redirect_valid;

    count_next = count;
    if (redirect_valid)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !push)
      count_next = count - CNT_ONE;

    fetch_pc_next = fetch_pc;
    if (redirect_valid)
      fetch_pc_next = redir_addr;
    else if (push)
      fetch_pc_next = fetch_pc + 32'd4;

    // A request is only launched when count_next leaves room for its ack.
    state_next = state;
    case (state)
      IDLE:
        if (!redirect_valid && (count_next < DEPTH_C)) state_next = REQ;
      REQ:
        if (mem_ack) begin
          if (!redirect_valid) state_next = (count_next < DEPTH_C) ? REQ : IDLE;
        end else if (redirect_valid) begin
          state_next = DISCARD;
        end
      DISCARD:
        if (mem_ack) state_next = REQ;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      // In DISCARD the address of the stale request is held until its ack.
      mem_req <= (state_next != IDLE);
      if (state_next == REQ) mem_addr <= fetch_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stor[wr_ptr] <= {fetch_pc, mem_rdata};
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue against a wait-stated memory model returning addr ^ key.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int          errors = 0;
  int          checks = 0;
  int          waits;
  int          wait_cnt;
  logic [31:0] key;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  // Memory model: ack after `waits` idle cycles of an active request.
  assign mem_ack   = mem_req && (wait_cnt == waits);
  assign mem_rdata = mem_addr ^ key;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) begin
      checks++;
      assert (dut.count <= 3'd4) else begin
        errors++;
        $error("FAIL overflow observed=%0d expected<=4", dut.count);
      end
    end
  endtask

  // Leaves the bench in cycle 0: reset released, DUT in IDLE.
  task automatic do_reset(input int w, input logic [31:0] k, input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    waits = w;
    key = k;
    out_ready = rdy;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b1;
    waits = 0;
    key = 32'd0;
    #1;
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_mem_addr",  mem_addr,           32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc",    out_pc,             32'd0);
    check("rst_out_instr", out_instr,          32'd0);
    check("rst_count",     {29'd0, dut.count}, 32'd0);

    // Zero-wait streaming, then redirect with ack+pop, then wrap-around redirect.
    do_reset(0, 32'd0, 1'b1);
    check("c0_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("c1_mem_req",  {31'd0, mem_req}, 32'd1);
    check("c1_mem_addr", mem_addr, 32'd0);
    check("c1_out_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc",    out_pc,    32'(4 * (k - 2)));
      check("stream_instr", out_instr, 32'(4 * (k - 2)));
      check("stream_addr",  mem_addr,  32'(4 * (k - 1)));
    end
    key = 32'h1234_0000;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("rdack_valid", {31'd0, out_valid}, 32'd0);
    check("rdack_count", {29'd0, dut.count}, 32'd0);
    check("rdack_req",   {31'd0, mem_req}, 32'd1);
    check("rdack_addr",  mem_addr, 32'h0000_0200);
    tick();
    check("rdack_pc",    out_pc, 32'h0000_0200);
    check("rdack_instr", out_instr, 32'h1234_0200);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr0",  mem_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check("wrap_addr1",  mem_addr, 32'h0000_0000);
    check("wrap_pc0",    out_pc, 32'hFFFF_FFFC);
    check("wrap_instr0", out_instr, 32'hEDCB_FFFC);
    tick();
    check("wrap_pc1",    out_pc, 32'h0000_0000);
    check("wrap_addr2",  mem_addr, 32'h0000_0004);

    // Backpressure: queue fills to DEPTH, then a single pop reopens fetching.
    do_reset(0, 32'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("fill_req",  {31'd0, mem_req}, 32'd1);
      check("fill_addr", mem_addr, 32'(4 * (k - 1)));
    end
    for (int k = 5; k <= 7; k++) begin
      tick();
      check("full_req",   {31'd0, mem_req}, 32'd0);
      check("full_count", {29'd0, dut.count}, 32'd4);
      check("full_pc",    out_pc, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop1_pc",    out_pc, 32'd4);
    check("pop1_count", {29'd0, dut.count}, 32'd3);
    check("pop1_req",   {31'd0, mem_req}, 32'd1);
    check("pop1_addr",  mem_addr, 32'd16);
    tick();
    check("refill_req",   {31'd0, mem_req}, 32'd0);
    check("refill_count", {29'd0, dut.count}, 32'd4);

    // Three wait states, redirect during the wait: stale data must be discarded.
    do_reset(3, 32'hA5A5_0000, 1'b1);
    tick();
    check("ws_c1_addr", mem_addr, 32'd0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check("ws_c3_req",   {31'd0, mem_req}, 32'd1);
    check("ws_c3_addr",  mem_addr, 32'd0);
    check("ws_c3_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("ws_c4_ack",  {31'd0, mem_ack}, 32'd1);
    check("ws_c4_addr", mem_addr, 32'd0);
    for (int k = 5; k <= 8; k++) begin
      tick();
      check("ws_new_addr", mem_addr, 32'h0000_0100);
      check("ws_no_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    check("ws_valid", {31'd0, out_valid}, 32'd1);
    check("ws_pc",    out_pc, 32'h0000_0100);
    check("ws_instr", out_instr, 32'hA5A5_0100);

    // Asynchronous reset with a request outstanding and two entries queued.
    do_reset(0, 32'd0, 1'b0);
    tick();
    tick();
    tick();
    check("ar_pre_count", {29'd0, dut.count}, 32'd2);
    check("ar_pre_req",   {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("ar_req",   {31'd0, mem_req}, 32'd0);
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_restart_req",  {31'd0, mem_req}, 32'd1);
    check("ar_restart_addr", mem_addr, 32'd0);
    tick();
    check("ar_restart_pc",    out_pc, 32'd0);
    check("ar_restart_count", {29'd0, dut.count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
